// File: rtl/vid_timing_pkg.sv
// Shared types and constants for the video timing generator and its
// downstream TMDS encoders.
package vid_timing_pkg;

    // Pixel as carried between the colour pipeline, the timing generator
    // and the encoders.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_pixel_t;

    // Default 640x480@60 timing
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CNT_W    = 12;

    // TMDS control-period symbols, indexed by {C1,C0}
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    // Red and green encoders carry no sync information
    localparam logic [1:0] TMDS_RG_CTRL = 2'b00;

    // Blue encoder pairs C0 with hsync and C1 with vsync
    function automatic logic [1:0] tmds_blue_ctrl(input logic vsync, input logic hsync);
        return {vsync, hsync};
    endfunction

    // Control symbol the encoder emits during blanking for a given {C1,C0}
    function automatic logic [9:0] tmds_ctrl_code(input logic [1:0] c);
        logic [9:0] code;
        case (c)
            2'b00:   code = TMDS_CTRL_00;
            2'b01:   code = TMDS_CTRL_01;
            2'b10:   code = TMDS_CTRL_10;
            default: code = TMDS_CTRL_11;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/vid_timing_gen_if.sv
// Pixel request handshake from the colour pipeline plus the registered
// video bus towards the TMDS encoders.
interface vid_timing_gen_if #(
    parameter int CNT_W = 12
);
    import vid_timing_pkg::*;

    rgb_pixel_t         pix_in;
    logic               pix_valid;
    logic               pix_req;
    rgb_pixel_t         rgb_out;
    logic               data_enable;
    logic               hsync;
    logic               vsync;
    logic [CNT_W-1:0]   x_out;
    logic [CNT_W-1:0]   y_out;
    logic               frame_start;

    // Timing generator side
    modport master (
        input  pix_in, pix_valid,
        output pix_req, rgb_out, data_enable, hsync, vsync,
               x_out, y_out, frame_start
    );

    // Pixel source / video sink side
    modport slave (
        output pix_in, pix_valid,
        input  pix_req, rgb_out, data_enable, hsync, vsync,
               x_out, y_out, frame_start
    );

endinterface

// File: rtl/vid_axis_counter.sv
// Modulo-TOTAL counter for one display axis; wrap flags the increment
// that returns the count to zero.
module vid_axis_counter #(
    parameter int TOTAL = 800,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

    assign wrap = inc & (cnt == LAST);

    // Hold at zero while cleared, otherwise count and wrap at TOTAL-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= wrap ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/vid_timing_gen.sv
// DVI/TMDS display timing generator. Walks a horizontal and a vertical
// counter, requests pixels from upstream during active video and registers
// pixel, qualifier, syncs and coordinates with one cycle of latency.
module vid_timing_gen
    import vid_timing_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP,
    parameter bit HS_ACT_HIGH = 1'b0,
    parameter bit VS_ACT_HIGH = 1'b0,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              clr_underflow,
    output logic              underflow,
    vid_timing_gen_if.master  vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_IDLE = ~HS_ACT_HIGH;
    localparam logic VS_IDLE = ~VS_ACT_HIGH;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             run_n;
    logic             at_origin;
    logic             hs_act;
    logic             vs_act;
    logic             pix_req;

    assign run_n = ~run;

    // Horizontal counter free-runs while enabled
    vid_axis_counter #(
        .TOTAL (H_TOTAL),
        .CNT_W (CNT_W)
    ) u_h_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (run_n),
        .inc  (run),
        .cnt  (h_cnt),
        .wrap (h_wrap)
    );

    // Vertical counter steps once per line
    vid_axis_counter #(
        .TOTAL (V_TOTAL),
        .CNT_W (CNT_W)
    ) u_v_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (run_n),
        .inc  (h_wrap),
        .cnt  (v_cnt),
        .wrap (v_wrap)
    );

    // Tracks "counters sit at (0,0)": true while idle and right after the
    // last pixel of a frame, so frame_start needs no wide compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            at_origin <= 1'b1;
        else if (!run)
            at_origin <= 1'b1;
        else
            at_origin <= v_wrap;
    end

    assign pix_req     = run & (h_cnt < H_ACT_C) & (v_cnt < V_ACT_C);
    assign vid.pix_req = pix_req;

    // Vsync spans whole lines, so it only looks at v_cnt
    assign hs_act = run & (h_cnt >= HS_BEG_C) & (h_cnt < HS_END_C);
    assign vs_act = run & (v_cnt >= VS_BEG_C) & (v_cnt < VS_END_C);

    // One-cycle output register stage feeding the encoders
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid.rgb_out     <= '0;
            vid.data_enable <= 1'b0;
            vid.hsync       <= HS_IDLE;
            vid.vsync       <= VS_IDLE;
            vid.x_out       <= '0;
            vid.y_out       <= '0;
            vid.frame_start <= 1'b0;
        end else begin
            vid.rgb_out     <= (pix_req & vid.pix_valid) ? vid.pix_in : '0;
            vid.data_enable <= pix_req;
            vid.hsync       <= hs_act ? HS_ACT_HIGH : HS_IDLE;
            vid.vsync       <= vs_act ? VS_ACT_HIGH : VS_IDLE;
            vid.x_out       <= pix_req ? h_cnt : '0;
            vid.y_out       <= pix_req ? v_cnt : '0;
            vid.frame_start <= run & at_origin;
        end
    end

    // Sticky underflow; a new miss beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            underflow <= 1'b0;
        else if (pix_req & ~vid.pix_valid)
            underflow <= 1'b1;
        else if (clr_underflow)
            underflow <= 1'b0;
    end

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed bench for vid_timing_gen on a tiny 8x6 raster.
module tb_vid_timing_gen;
    import vid_timing_pkg::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst, run, clr_underflow, underflow;

    vid_timing_gen_if #(.CNT_W(CW)) vif();

    vid_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_ACT_HIGH(1'b0), .VS_ACT_HIGH(1'b0), .CNT_W(CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .clr_underflow (clr_underflow),
        .underflow     (underflow),
        .vid           (vif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          de, hs, vs, fs;
        logic [23:0] rgb;
        int          x, y;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int n = 0;

    // Bench raster position and the inputs applied in the current cycle
    int hp = 0, vp = 0, ul_m = 0;
    bit s_run, s_req, s_valid, s_clr;
    int s_h, s_v;
    logic [23:0] s_pix;

    function automatic logic [23:0] pat(input int h, input int v);
        return {8'(h), 8'(v), 8'hC3};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, n, act, exp);
        end
    endtask

    task automatic drive(input bit r, input bit valid, input bit clr);
        run = r;
        vif.pix_valid = valid;
        clr_underflow = clr;
        vif.pix_in = pat(hp, vp);
    endtask

    // Close one cycle: check pix_req, clock, then check every output
    // against what the spec says the previous cycle should produce.
    task automatic step();
        #1;
        s_run = run; s_valid = vif.pix_valid; s_clr = clr_underflow;
        s_h = hp; s_v = vp; s_pix = vif.pix_in;
        s_req = run && hp < 4 && vp < 3;
        chk("pix_req", 32'(vif.pix_req), 32'(s_req));
        @(posedge clk); #1; n++;
        if (s_run) begin
            hp = (hp + 1) % 8;
            if (hp == 0) vp = (vp + 1) % 6;
        end else begin
            hp = 0; vp = 0;
        end
        if (s_req && !s_valid) ul_m = 1;
        else if (s_clr) ul_m = 0;
        chk("m_de",  32'(vif.data_enable), 32'(s_req));
        chk("m_rgb", 32'(vif.rgb_out), (s_req && s_valid) ? 32'(s_pix) : 32'd0);
        chk("m_x",   32'(vif.x_out), s_req ? 32'(s_h) : 32'd0);
        chk("m_y",   32'(vif.y_out), s_req ? 32'(s_v) : 32'd0);
        chk("m_fs",  32'(vif.frame_start), 32'(s_run && s_h == 0 && s_v == 0));
        chk("m_hs",  32'(vif.hsync), 32'(!(s_run && s_h >= 5 && s_h < 7)));
        chk("m_vs",  32'(vif.vsync), 32'(!(s_run && s_v == 4)));
        chk("m_ul",  32'(underflow), 32'(ul_m));
    endtask

    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1,  1,1,1,1, 24'h0000C3, 0,0};
        tbl[1]  = '{2,  1,1,1,0, 24'h0100C3, 1,0};
        tbl[2]  = '{4,  1,1,1,0, 24'h0300C3, 3,0};
        tbl[3]  = '{5,  0,1,1,0, 24'h000000, 0,0};
        tbl[4]  = '{6,  0,0,1,0, 24'h000000, 0,0};
        tbl[5]  = '{7,  0,0,1,0, 24'h000000, 0,0};
        tbl[6]  = '{8,  0,1,1,0, 24'h000000, 0,0};
        tbl[7]  = '{9,  1,1,1,0, 24'h0001C3, 0,1};
        tbl[8]  = '{12, 1,1,1,0, 24'h0301C3, 3,1};
        tbl[9]  = '{17, 1,1,1,0, 24'h0002C3, 0,2};
        tbl[10] = '{25, 0,1,1,0, 24'h000000, 0,0};
        tbl[11] = '{33, 0,1,0,0, 24'h000000, 0,0};
        tbl[12] = '{38, 0,0,0,0, 24'h000000, 0,0};
        tbl[13] = '{40, 0,1,0,0, 24'h000000, 0,0};
        tbl[14] = '{41, 0,1,1,0, 24'h000000, 0,0};
        tbl[15] = '{49, 1,1,1,1, 24'h0000C3, 0,0};
        tbl[16] = '{97, 1,1,1,1, 24'h0000C3, 0,0};

        rst = 1'b1; run = 1'b0; clr_underflow = 1'b0;
        vif.pix_valid = 1'b1; vif.pix_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_de",  32'(vif.data_enable), 32'd0);
        chk("rst_hs",  32'(vif.hsync), 32'd1);
        chk("rst_vs",  32'(vif.vsync), 32'd1);
        chk("rst_rgb", 32'(vif.rgb_out), 32'd0);
        chk("rst_fs",  32'(vif.frame_start), 32'd0);
        chk("rst_ul",  32'(underflow), 32'd0);

        @(negedge clk) rst = 1'b0;
        drive(0, 1, 0);
        step();

        // Two full frames plus a bit, run rising at cycle 0
        n = 0;
        drive(1, 1, 0);
        for (int c = 1, idx = 0; c <= 100; c++) begin
            step();
            if (idx < 17 && tbl[idx].cyc == n) begin
                chk("tbl_de",  32'(vif.data_enable), 32'(tbl[idx].de));
                chk("tbl_hs",  32'(vif.hsync), 32'(tbl[idx].hs));
                chk("tbl_vs",  32'(vif.vsync), 32'(tbl[idx].vs));
                chk("tbl_fs",  32'(vif.frame_start), 32'(tbl[idx].fs));
                chk("tbl_rgb", 32'(vif.rgb_out), 32'(tbl[idx].rgb));
                chk("tbl_x",   32'(vif.x_out), 32'(tbl[idx].x));
                chk("tbl_y",   32'(vif.y_out), 32'(tbl[idx].y));
                idx++;
            end
            // Blue encoder control symbol during blanking
            if (n == 5)  chk("enc_c11", 32'(tmds_ctrl_code(tmds_blue_ctrl(vif.vsync, vif.hsync))), 32'(10'b1010101011));
            if (n == 6)  chk("enc_c10", 32'(tmds_ctrl_code(tmds_blue_ctrl(vif.vsync, vif.hsync))), 32'(10'b0101010100));
            if (n == 33) chk("enc_c01", 32'(tmds_ctrl_code(tmds_blue_ctrl(vif.vsync, vif.hsync))), 32'(10'b0010101011));
            if (n == 38) chk("enc_c00", 32'(tmds_ctrl_code(tmds_blue_ctrl(vif.vsync, vif.hsync))), 32'(10'b1101010100));
            drive(1, 1, 0);
        end

        // Underflow, clear, set-beats-clear, then run drop and restart
        while (n < 208) begin
            step();
            case (n)
                107: begin
                    chk("uf_set", 32'(underflow), 32'd1);
                    chk("uf_rgb", 32'(vif.rgb_out), 32'd0);
                    chk("uf_x",   32'(vif.x_out), 32'd2);
                    chk("uf_y",   32'(vif.y_out), 32'd1);
                end
                108: chk("uf_next_rgb", 32'(vif.rgb_out), 32'h0301C3);
                160: chk("uf_hold", 32'(underflow), 32'd1);
                162: chk("uf_clr", 32'(underflow), 32'd0);
                194: begin
                    chk("uf_set_wins", 32'(underflow), 32'd1);
                    chk("uf_rgb2", 32'(vif.rgb_out), 32'd0);
                end
                195: chk("uf_clr2", 32'(underflow), 32'd0);
                202: begin
                    chk("drop_de", 32'(vif.data_enable), 32'd0);
                    chk("drop_hs", 32'(vif.hsync), 32'd1);
                    chk("drop_vs", 32'(vif.vsync), 32'd1);
                    chk("drop_x",  32'(vif.x_out), 32'd0);
                end
                206: begin
                    chk("rerun_fs",  32'(vif.frame_start), 32'd1);
                    chk("rerun_de",  32'(vif.data_enable), 32'd1);
                    chk("rerun_rgb", 32'(vif.rgb_out), 32'h0000C3);
                end
                default: ;
            endcase
            drive(!(n >= 201 && n < 205),
                  !(n == 106 || n == 193),
                  (n == 161 || n == 193 || n == 194));
        end

        // Asynchronous reset in the middle of an active line
        chk("pre_rst_de", 32'(vif.data_enable), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_de",  32'(vif.data_enable), 32'd0);
        chk("arst_hs",  32'(vif.hsync), 32'd1);
        chk("arst_vs",  32'(vif.vsync), 32'd1);
        chk("arst_rgb", 32'(vif.rgb_out), 32'd0);
        @(negedge clk) rst = 1'b0;
        hp = 0; vp = 0; ul_m = 0;
        drive(1, 1, 0);
        step();
        chk("rel_fs", 32'(vif.frame_start), 32'd1);
        chk("rel_x",  32'(vif.x_out), 32'd0);
        chk("rel_y",  32'(vif.y_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vid_timing_gen.md
Name: vid_timing_gen

Overview:
- Generates DVI/TMDS display timing: horizontal and vertical counters, hsync, vsync, data_enable and pixel coordinates.
- Pulls RGB pixels from the upstream colour-processing pipeline with a request/valid handshake.
- Sits directly upstream of the three per-channel TMDS encoders:
  - data_enable drives each encoder's data_enable.
  - The blue encoder takes C0=hsync, C1=vsync; red and green take C0=C1=0.
  - rgb_out bytes drive the encoders' d_in.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch cycles
- H_SYNC, 96, hsync pulse cycles
- H_BP, 48, horizontal back porch cycles
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vsync pulse lines
- V_BP, 33, vertical back porch lines
- HS_ACT_HIGH, 0, 1 = hsync active-high, 0 = active-low
- VS_ACT_HIGH, 0, 1 = vsync active-high, 0 = active-low
- CNT_W, 12, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- run  in  1  timing enable
- pix_in  in  24  upstream pixel {R[23:16],G[15:8],B[7:0]}
- pix_valid  in  1  pix_in valid this cycle
- pix_req  out  1  combinational; requests one pixel this cycle
- clr_underflow  in  1  clears the underflow flag
- rgb_out  out  24  registered pixel for the encoders
- data_enable  out  1  active-video qualifier
- hsync  out  1  horizontal sync at configured polarity
- vsync  out  1  vertical sync at configured polarity
- x_out  out  CNT_W  column of rgb_out; 0 outside active video
- y_out  out  CNT_W  row of rgb_out; 0 outside active video
- frame_start  out  1  one-cycle pulse aligned with pixel (0,0)
- underflow  out  1  sticky; a requested pixel was missing

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active, front porch, sync, back porch. Frame order is the same, counted in lines.
- h_cnt advances every clk while run=1 and wraps H_TOTAL-1 -> 0. v_cnt advances when h_cnt wraps and wraps V_TOTAL-1 -> 0.
- run=0: both counters held at 0; registered outputs take their reset values on the next edge.
- run rising: frame starts at h_cnt=0, v_cnt=0, so the first output cycle is pixel (0,0) with frame_start=1.
- pix_req = run & (h_cnt < H_ACTIVE) & (v_cnt < V_ACTIVE).
- Upstream must present pix_valid=1 in the same cycle as pix_req. The pixel is captured on that edge.
- pix_valid while pix_req=0 is ignored.
- Latency is 1 cycle. Every registered output reflects the previous cycle's h_cnt/v_cnt:
  - data_enable <= pix_req
  - rgb_out <= pix_req & pix_valid ? pix_in : 0
  - x_out/y_out <= h_cnt/v_cnt when pix_req, else 0
  - frame_start <= run & h_cnt==0 & v_cnt==0
  - hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vsync active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines, edges at h_cnt=0
- Underflow:
  - pix_req=1 and pix_valid=0 -> rgb_out=0 for that pixel and underflow set. Timing never stalls.
  - underflow clears only on clr_underflow=1.
  - If set and clear occur in the same cycle, set wins.
- Reset values:
  - rgb_out, x_out, y_out, data_enable, frame_start, underflow = 0
  - hsync = ~HS_ACT_HIGH; vsync = ~VS_ACT_HIGH
  - counters = 0
- Reset mid-frame: outputs go to reset values immediately (asynchronous). After release with run=1, the frame restarts at (0,0).
- Wrap-around: the last pixel of the last line is followed by the full blanking interval, then a new frame_start. No gap cycle.

Decomposition:
- Package vid_timing_pkg holds:
  - rgb_pixel_t packed struct {r,g,b} of 8 bits each
  - default 640x480@60 timing constants
  - TMDS control-pairing constants for the blue channel
- Sub-module vid_axis_counter (parameters TOTAL, CNT_W; ports clk, rst, clr, inc, cnt, wrap), instantiated once for horizontal and once for vertical.

Test Plan:
- Bench parameters: H=4/1/2/1 (H_TOTAL 8), V=3/1/1/1 (V_TOTAL 6), active-low syncs, pix_valid held 1, rgb from a {x,y} pattern.
- Reset: assert rst mid-line -> in the same timestep data_enable=0, hsync=vsync=1, rgb_out=0. Release with run=1 -> frame_start on the first output cycle, x_out=y_out=0.
- Line timing: run rises at cycle 0 -> data_enable=1 on cycles 1-4, hsync=0 on cycles 6-7, pattern repeats every 8 cycles. rgb_out/x_out follow pix_in and match column 0..3.
- Frame timing: vsync=0 for cycles 33-40. data_enable never high on lines 3-5. frame_start on cycles 1, 49, 97.
- Underflow: pix_valid=0 while pix_req at (2,1) -> rgb_out=0x000000 on the next cycle, underflow=1. It holds through the next frame. clr_underflow pulse clears it. A simultaneous new underflow keeps it 1.
- Run drop: run=0 mid-active -> next cycle data_enable=0, syncs idle. Re-raise -> restart at (0,0) with frame_start.
- Encoder integration: hsync/vsync/data_enable drive the encoder with blue C0/C1 mapping -> during blanking the encoder output matches the control code for {vsync,hsync}.
